// File: rtl/lzx_decoder2x4.sv
// Registered 2-to-4 decoder with active-high enable and active-low one-cold outputs.
// Outputs come straight from flops, so selects downstream are glitch-free.
module lzx_decoder2x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic [3:0] y
);

  logic [1:0] sel;
  logic [3:0] y_next;

  assign sel = {a, b};

  // Idle value is all-high; at most one line is pulled low when enabled.
  always_comb begin
    y_next = 4'b1111;
    if (en) begin
      unique case (sel)
        2'd0: y_next = 4'b1110;
        2'd1: y_next = 4'b1101;
        2'd2: y_next = 4'b1011;
        2'd3: y_next = 4'b0111;
        default: y_next = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) y <= 4'b1111;
    else     y <= y_next;
  end

endmodule

// File: tb/tb_lzx_decoder2x4.sv
// Directed and random checks for the registered 2-to-4 active-low decoder.
module tb_lzx_decoder2x4;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       en;
  logic [3:0] y;

  int total = 0;
  int bad   = 0;

  lzx_decoder2x4 dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .en (en),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then take one rising edge and settle just after it.
  task automatic step(input logic r, input logic e, input logic aa, input logic bb);
    rst = r; en = e; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dec_ref(input logic r, input logic e, input logic aa, input logic bb);
    logic [3:0] v;
    v = 4'b1111;
    if (!r && e) begin
      case ({aa, bb})
        2'b00: v = 4'b1110;
        2'b01: v = 4'b1101;
        2'b10: v = 4'b1011;
        default: v = 4'b0111;
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    step(1, 1, 1, 1);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL reset_edge1: y=%b expected %b", y, 4'b1111); end
    step(1, 1, 1, 1);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL reset_edge2: y=%b expected %b", y, 4'b1111); end
    step(0, 1, 1, 1);
    total++;
    if (y !== 4'b0111) begin bad++; $display("FAIL reset_release: y=%b expected %b", y, 4'b0111); end
  endtask

  task automatic test_disabled();
    step(0, 0, 0, 0);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL disabled_00: y=%b expected %b", y, 4'b1111); end
    step(0, 0, 1, 1);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL disabled_11: y=%b expected %b", y, 4'b1111); end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_tbl [4];
    logic [3:0] held;
    exp_tbl[0] = 4'b1110; exp_tbl[1] = 4'b1101;
    exp_tbl[2] = 4'b1011; exp_tbl[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i[1], i[0]);
      total++;
      if (y !== exp_tbl[i]) begin bad++; $display("FAIL sweep_sel%0d: y=%b expected %b", i, y, exp_tbl[i]); end
      // Toggle inputs between edges; the registered output must not move.
      held = y;
      a = ~a; b = ~b; en = ~en;
      #2;
      total++;
      if (y !== held) begin bad++; $display("FAIL hold_sel%0d: y=%b expected %b", i, y, held); end
    end
  endtask

  task automatic test_enable_drop();
    step(0, 1, 1, 0);
    total++;
    if (y !== 4'b1011) begin bad++; $display("FAIL endrop_on: y=%b expected %b", y, 4'b1011); end
    step(0, 0, 1, 0);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL endrop_off: y=%b expected %b", y, 4'b1111); end
    step(0, 1, 1, 0);
    total++;
    if (y !== 4'b1011) begin bad++; $display("FAIL endrop_restore: y=%b expected %b", y, 4'b1011); end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 0, 0);
    total++;
    if (y !== 4'b1110) begin bad++; $display("FAIL midrst_pre: y=%b expected %b", y, 4'b1110); end
    step(1, 1, 0, 1);
    total++;
    if (y !== 4'b1111) begin bad++; $display("FAIL midrst_pulse: y=%b expected %b", y, 4'b1111); end
    step(0, 1, 1, 0);
    total++;
    if (y !== 4'b1011) begin bad++; $display("FAIL midrst_resume: y=%b expected %b", y, 4'b1011); end
  endtask

  task automatic test_random();
    logic       r, e, aa, bb;
    logic [3:0] exp_y;
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      aa = $urandom_range(0, 1);
      bb = $urandom_range(0, 1);
      exp_y = dec_ref(r, e, aa, bb);
      step(r, e, aa, bb);
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL rand_model[%0d]: y=%b expected %b", i, y, exp_y); end
      total++;
      if ($countones(~y) > 1) begin bad++; $display("FAIL rand_onecold[%0d]: y=%b expected at most one zero", i, y); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0;
    test_reset();
    test_disabled();
    test_sweep();
    test_enable_drop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lzx_decoder2x4.md
Name: lzx_decoder2x4

Overview:
- Registered 2-to-4 line decoder with an active-high enable and active-low one-cold outputs.
- Used as a select/strobe generator in the gate-level library, wherever a 2-bit address picks one of four active-low targets.
- Outputs are registered on the single system clock, so downstream logic sees glitch-free selects.

Parameters:
- None. The widths are fixed: 2 select bits and 4 outputs.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- a    input  1  select MSB.
- b    input  1  select LSB.
- en   input  1  decoder enable, active-high.
- y    output 4  decoded outputs, active-low; at most one bit is 0 at a time.

Behaviour:
- Select index: sel = {a, b}, with a as the MSB and b as the LSB.
- Next-state function, evaluated every rising edge of clk:
  - If rst = 1: y <= 4'b1111. Reset has priority over en, a and b.
  - Else if en = 0: y <= 4'b1111. No output is selected, whatever a and b are.
  - Else, y <= the complement of (1 << sel):
    - a=0, b=0 -> y = 4'b1110 (y[0] low)
    - a=0, b=1 -> y = 4'b1101 (y[1] low)
    - a=1, b=0 -> y = 4'b1011 (y[2] low)
    - a=1, b=1 -> y = 4'b0111 (y[3] low)
- Latency: exactly 1 clk cycle from input sample to y.
- No combinational path from a, b or en to y.
- Reset value of y is 4'b1111. This is also the power-up target once rst has been applied for at least one edge.
- Reset asserted mid-operation: y goes to 4'b1111 on the first rising edge with rst = 1 and holds while rst stays high.
- First edge after rst deasserts: y reflects the a, b and en values sampled on that edge.
- Between edges, y holds its value, even if inputs toggle.
- Invariant: y is always either 4'b1111 or has exactly one bit low. It never has two or more zeros.
- No handshake, no FSM, no X-propagation masking. X or Z inputs are out of contract.

Test Plan:
- Reset: drive rst=1 with en=1, a=1, b=1 for 2 edges -> y = 4'b1111 after the first edge and stays there. Release rst -> y = 4'b0111 on the next edge.
- Disabled: rst=0, en=0, a=0, b=0, then en=0, a=1, b=1, one edge each -> y = 4'b1111 both times.
- Full decode sweep: en=1 with {a,b} = 00, 01, 10, 11, one per edge -> y = 1110, 1101, 1011, 0111, each appearing one cycle after its input.
- Enable drop: en=1, a=1, b=0 (y=1011), then en=0 on the next edge -> y = 1111. Restore en=1 -> y = 1011.
- Mid-operation reset: while sweeping with en=1, pulse rst=1 for one edge at {a,b}=01 -> y = 1111 on that edge, then the decoded value resumes on the following edge.
- Invariant check: on every cycle of a random stimulus run, y is 1111 or has exactly one zero, and y matches a 1-cycle-delayed reference model.
